lane_merger: RTL and testbench

- Receive-side counterpart of the transmit lane distribution. It takes per-lane decoded bytes from the two lane decoders, removes inter-lane skew using the per-lane sync marker, and re-interleaves transport-layer data into a single byte stream for the data bus.
- Ordered-set traffic passes through on both lanes unchanged, registered.
- Transport data is interleaved on the wire in groups of GROUP bytes per lane, lane 0 first.

---
 rtl/lane_merger.sv | 222 ++++++++++++++++++++++
 tb/tb_lane_merger.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_merger.sv
// Receive-side lane merger: deskews two decoded lanes on their sync markers and
// re-interleaves transport bytes in GROUP-sized chunks; ordered sets pass through.

module lane_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         wr, rd;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr    = push && (!full || pop) && !flush;
  assign rd    = pop && !empty && !flush;
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= din;
  end
endmodule

module lane_merger #(
  parameter int GROUP      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_SKEW   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       data_os_i,
  input  logic [7:0] lane_0_in,
  input  logic       lane_0_vld,
  input  logic       lane_0_sync,
  input  logic [7:0] lane_1_in,
  input  logic       lane_1_vld,
  input  logic       lane_1_sync,
  output logic [7:0] lane_0_os_out,
  output logic [7:0] lane_1_os_out,
  output logic       os_vld,
  output logic [7:0] out_data,
  output logic       out_vld,
  output logic       aligned,
  output logic       skew_err,
  output logic       ovf_err
);
  localparam int NUM_LANES = 2;
  localparam int SKW       = $clog2(MAX_SKEW + 2);
  localparam int GW        = $clog2(GROUP);
  localparam logic [SKW-1:0] SKEW_LIM = SKW'(MAX_SKEW);
  localparam logic [GW-1:0]  GRP_LAST = GW'(GROUP - 1);

  typedef enum logic [2:0] {IDLE, OS_PASS, ALIGN, MERGE, ERROR} state_t;

  state_t                          state, nxt;
  logic [NUM_LANES-1:0][7:0]       din, dout;
  logic [NUM_LANES-1:0]            vld, syn, synced, sync_all;
  logic [NUM_LANES-1:0]            push, pop, empty, full, ovf;
  logic                            flush, skew_hit, keep, sel;
  logic [SKW-1:0]                  skew;
  logic [GW-1:0]                   grp;
  logic [1:0]                      vld_pipe;
  logic [7:0]                      stage_data;

  assign din      = {lane_1_in, lane_0_in};
  assign vld      = {lane_1_vld, lane_0_vld};
  assign syn      = {lane_1_sync & lane_1_vld, lane_0_sync & lane_0_vld};
  assign sync_all = synced | syn;
  assign keep     = (state == MERGE) && (nxt == MERGE);
  assign out_vld  = vld_pipe[1];
  assign aligned  = (state == MERGE);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .dout  (dout[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  always_comb begin
    nxt      = state;
    flush    = 1'b0;
    push     = '0;
    pop      = '0;
    skew_hit = 1'b0;
    if (!enable) begin
      nxt   = IDLE;
      flush = 1'b1;
    end else begin
      case (state)
        IDLE:    nxt = data_os_i ? ALIGN : OS_PASS;
        OS_PASS: if (data_os_i) nxt = ALIGN;
        ALIGN: begin
          if (!data_os_i) begin
            nxt   = OS_PASS;
            flush = 1'b1;
          end else begin
            // A lane starts storing at its own sync byte.
            push = vld & sync_all;
            if (&sync_all) nxt = MERGE;
            else if ((|synced) && (skew == SKEW_LIM)) begin
              nxt      = ERROR;
              skew_hit = 1'b1;
            end
          end
        end
        MERGE: begin
          if (!data_os_i) begin
            nxt   = OS_PASS;
            flush = 1'b1;
          end else begin
            pop[sel] = !empty[sel];
            push     = vld;
          end
        end
        default: ;
      endcase
    end
    ovf = push & full & ~pop;
    if (|ovf) nxt = ERROR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      synced        <= '0;
      skew          <= '0;
      sel           <= 1'b0;
      grp           <= '0;
      skew_err      <= 1'b0;
      ovf_err       <= 1'b0;
      lane_0_os_out <= '0;
      lane_1_os_out <= '0;
      os_vld        <= 1'b0;
      vld_pipe      <= '0;
      stage_data    <= '0;
      out_data      <= '0;
    end else begin
      state <= nxt;
      if (!enable) begin
        synced        <= '0;
        skew          <= '0;
        sel           <= 1'b0;
        grp           <= '0;
        skew_err      <= 1'b0;
        ovf_err       <= 1'b0;
        lane_0_os_out <= '0;
        lane_1_os_out <= '0;
        os_vld        <= 1'b0;
        vld_pipe      <= '0;
        stage_data    <= '0;
        out_data      <= '0;
      end else begin
        // Skew count is 1 on the first-sync edge, so it equals cycles waited so far.
        if (state == ALIGN && (nxt == ALIGN || skew_hit)) begin
          synced <= sync_all;
          if (|synced)   skew <= skew + 1'b1;
          else if (|syn) skew <= SKW'(1);
        end else if (nxt != ERROR) begin
          synced <= '0;
          skew   <= '0;
        end

        if (state == MERGE && (|pop)) begin
          grp <= grp + 1'b1;
          if (grp == GRP_LAST) sel <= ~sel;
        end else if (state != MERGE) begin
          grp <= '0;
          sel <= 1'b0;
        end

        if (skew_hit) skew_err <= 1'b1;
        if (|ovf)     ovf_err  <= 1'b1;

        os_vld <= (state == OS_PASS) && (&vld);
        if (state == OS_PASS) begin
          lane_0_os_out <= lane_0_in;
          lane_1_os_out <= lane_1_in;
        end

        // Popped byte is staged one cycle before it reaches out_data.
        vld_pipe[0] <= keep && (|pop);
        vld_pipe[1] <= keep && vld_pipe[0];
        if (|pop) stage_data <= dout[sel];
        if (keep && vld_pipe[0]) out_data <= stage_data;
      end
    end
  end
endmodule

// File: tb/tb_lane_merger.sv
// Directed bench for lane_merger: a queue-based interleave model checks every
// merged byte and every os output; literal expectations pin timing and flags.

module tb_lane_merger;
  localparam int GROUP = 4;

  logic       clk = 1'b0, rst = 1'b0, enable = 1'b0, data_os_i = 1'b0;
  logic [7:0] lane_0_in = '0, lane_1_in = '0;
  logic       lane_0_vld = 1'b0, lane_0_sync = 1'b0, lane_1_vld = 1'b0, lane_1_sync = 1'b0;
  logic [7:0] lane_0_os_out, lane_1_os_out, out_data;
  logic       os_vld, out_vld, aligned, skew_err, ovf_err;

  always #5 clk = ~clk;

  lane_merger #(.GROUP(4), .FIFO_DEPTH(8), .MAX_SKEW(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_os_i(data_os_i),
    .lane_0_in(lane_0_in), .lane_0_vld(lane_0_vld), .lane_0_sync(lane_0_sync),
    .lane_1_in(lane_1_in), .lane_1_vld(lane_1_vld), .lane_1_sync(lane_1_sync),
    .lane_0_os_out(lane_0_os_out), .lane_1_os_out(lane_1_os_out), .os_vld(os_vld),
    .out_data(out_data), .out_vld(out_vld), .aligned(aligned),
    .skew_err(skew_err), .ovf_err(ovf_err)
  );

  int total = 0, bad = 0;

  // Model: bytes each lane should have stored, drained GROUP at a time, lane 0 first.
  logic [7:0] mq0[$], mq1[$];
  int         msel = 0, mcnt = 0;
  bit         armed = 0, got0 = 0, got1 = 0, pass_mode = 0;
  logic       exp_osv = 1'b0;
  logic [7:0] exp_os0 = '0, exp_os1 = '0;

  logic       rv [32], rs [32], ro [32], ra [32];
  logic [7:0] rd [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    msel = 0; mcnt = 0; armed = 0; got0 = 0; got1 = 0;
  endtask

  task automatic cyc(input logic dos, input logic v0, input logic [7:0] d0, input logic s0,
                     input logic v1, input logic [7:0] d1, input logic s1);
    logic nv;
    data_os_i = dos;
    lane_0_vld = v0; lane_0_in = d0; lane_0_sync = s0;
    lane_1_vld = v1; lane_1_in = d1; lane_1_sync = s1;
    nv = pass_mode && enable && v0 && v1;
    if (armed) begin
      if (v0 && (got0 || s0)) begin mq0.push_back(d0); got0 = 1; end
      if (v1 && (got1 || s1)) begin mq1.push_back(d1); got1 = 1; end
    end
    @(posedge clk);
    exp_osv = nv; exp_os0 = d0; exp_os1 = d1;
    #1;
  endtask

  task automatic idle(input logic dos);
    cyc(dos, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic restart(input logic dos);
    pass_mode = 0;
    model_clear();
    enable = 1'b0;
    idle(1'b0);
    enable = 1'b1;
    idle(dos);
    pass_mode = !dos;
    armed = dos;
  endtask

  // Lane 0 sends 0x00.. from cycle off0; lane 1 sends 0x10.. from off1 with an
  // optional hole of gap_len cycles after its gap_at-th byte. First byte carries sync.
  task automatic stream(input int off0, input int n0, input int off1, input int n1,
                        input int gap_at, input int gap_len, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int k0, k1, j1;
      logic v0, v1, s0, s1;
      logic [7:0] d0, d1;
      k0 = c - off0;
      v0 = (k0 >= 0) && (k0 < n0);
      d0 = 8'(k0);
      s0 = v0 && (k0 == 0);
      k1 = c - off1;
      j1 = k1;
      v1 = 1'b1;
      if (k1 >= gap_at && k1 < gap_at + gap_len) v1 = 1'b0;
      else if (k1 >= gap_at + gap_len) j1 = k1 - gap_len;
      v1 = v1 && (j1 >= 0) && (j1 < n1);
      d1 = 8'(8'h10 + j1);
      s1 = v1 && (j1 == 0);
      cyc(1'b1, v0, d0, s0, v1, d1, s1);
      rv[c] = out_vld; rs[c] = skew_err; ro[c] = ovf_err; ra[c] = aligned; rd[c] = out_data;
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    total++;
    if (os_vld !== exp_osv) begin
      bad++;
      $display("FAIL os_vld got=%0b want=%0b", os_vld, exp_osv);
    end
    if (exp_osv) begin
      total++;
      if ({lane_0_os_out, lane_1_os_out} !== {exp_os0, exp_os1}) begin
        bad++;
        $display("FAIL os_data got=%h/%h want=%h/%h", lane_0_os_out, lane_1_os_out, exp_os0, exp_os1);
      end
    end
    if (out_vld === 1'b1) begin
      total++;
      if ((msel == 0 && mq0.size() == 0) || (msel == 1 && mq1.size() == 0)) begin
        bad++;
        $display("FAIL out_unexpected got=%h want=none lane=%0d", out_data, msel);
      end else begin
        e = (msel == 0) ? mq0.pop_front() : mq1.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL out_data got=%h want=%h", out_data, e);
        end
        mcnt++;
        if (mcnt == GROUP) begin mcnt = 0; msel = 1 - msel; end
      end
    end
  end

  initial begin
    // reset state
    idle(1'b0);
    idle(1'b0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_os_vld", os_vld, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_errs", {skew_err, ovf_err}, 0);
    chk("rst_data", {out_data, lane_0_os_out, lane_1_os_out}, 0);
    rst = 1'b1;

    // ordered-set pass-through
    restart(1'b0);
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0);
    chk("os_l0", lane_0_os_out, 8'hA5);
    chk("os_l1", lane_1_os_out, 8'h3C);
    chk("os_vld", os_vld, 1);
    chk("os_out_vld", out_vld, 0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h22, 1'b0);
    chk("os_vld_one_lane", os_vld, 0);

    // zero skew
    restart(1'b1);
    stream(0, 8, 0, 8, 99, 0, 24);
    chk("z_aligned", ra[0], 1);
    chk("z_vld_e1", rv[1], 0);
    chk("z_vld_e2", rv[2], 1);
    chk("z_first", rd[2], 8'h00);
    chk("z_switch", rd[6], 8'h10);
    chk("z_back", rd[10], 8'h04);
    chk("z_drained", mq0.size() + mq1.size(), 0);

    // skew 3, lane 1 late
    restart(1'b1);
    stream(0, 8, 3, 8, 99, 0, 24);
    chk("s3_err", rs[23], 0);
    chk("s3_drained", mq0.size() + mq1.size(), 0);

    // skew exactly MAX_SKEW
    restart(1'b1);
    stream(0, 8, 4, 8, 99, 0, 24);
    chk("s4_not_aligned", ra[3], 0);
    chk("s4_aligned", ra[4], 1);
    chk("s4_err", rs[23], 0);
    chk("s4_drained", mq0.size() + mq1.size(), 0);

    // lane 1 starves mid-group
    restart(1'b1);
    stream(0, 8, 0, 8, 2, 6, 24);
    chk("st_vld7", rv[7], 1);
    chk("st_gap8", rv[8], 0);
    chk("st_gap9", rv[9], 0);
    chk("st_resume", rv[10], 1);
    chk("st_byte", rd[10], 8'h12);
    chk("st_drained", mq0.size() + mq1.size(), 0);

    // skew MAX_SKEW+1 -> error, no output
    restart(1'b1);
    armed = 0;
    stream(0, 8, 5, 8, 99, 0, 12);
    chk("s5_err_e3", rs[3], 0);
    chk("s5_err_e4", rs[4], 1);
    chk("s5_err_hold", rs[11], 1);
    chk("s5_aligned", ra[11], 0);
    chk("s5_out_vld", rv[11], 0);
    enable = 1'b0;
    idle(1'b0);
    chk("s5_err_clr", skew_err, 0);

    // overflow: lane 1 stalls after its sync byte
    restart(1'b1);
    stream(0, 13, 0, 1, 99, 0, 16);
    chk("ov_e11", ro[11], 0);
    chk("ov_e12", ro[12], 1);
    chk("ov_aligned_pre", ra[11], 1);
    chk("ov_error", ra[12], 0);
    chk("ov_out_vld", rv[15], 0);
    enable = 1'b0;
    idle(1'b0);
    chk("ov_clr", ovf_err, 0);

    // data_os_i drops in MERGE with bytes buffered
    restart(1'b1);
    stream(0, 4, 0, 1, 99, 0, 4);
    chk("md_vld3", rv[3], 1);
    chk("md_byte3", rd[3], 8'h01);
    armed = 0;
    idle(1'b0);
    chk("md_flush_vld", out_vld, 0);
    model_clear();
    pass_mode = 1;
    cyc(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 8'hC3, 1'b0);
    chk("md_os_vld", os_vld, 1);
    chk("md_os", {lane_0_os_out, lane_1_os_out}, 16'h5AC3);
    idle(1'b0);
    idle(1'b0);
    chk("md_no_out", out_vld, 0);

    // async reset mid-MERGE
    restart(1'b1);
    stream(0, 8, 0, 8, 99, 0, 4);
    chk("ar_vld", rv[3], 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_out_vld", out_vld, 0);
    chk("ar_aligned", aligned, 0);
    chk("ar_data", out_data, 0);
    chk("ar_os", {os_vld, skew_err, ovf_err}, 0);
    model_clear();
    pass_mode = 0;
    idle(1'b0);
    rst = 1'b1;
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
